serial_adder: RTL and testbench
===============================

# serial_adder

Bit-serial WIDTH-bit adder built around the existing single-bit `fulladder` cell. It accepts two parallel operands and a carry-in on a `start` pulse. It then feeds the full adder one bit pair per clock, LSB first, with the carry held in a flip-flop between bits. The block sits directly upstream of the `fulladder`: it sequences operand bits into the cell and collects its `s`/`c_out` into a parallel result with a done pulse.

## Interface
Parameters:
- `WIDTH`, default 8: operand and result width in bits; legal range 2..32.

Ports:
- `clk`, in, 1: single clock; all state changes on the rising edge.
- `rst_n`, in, 1: reset, asynchronous and active-low.
- `start`, in, 1: request to begin an addition; sampled on the rising edge.
- `a`, in, WIDTH: operand A; captured on an accepted start.
- `b`, in, WIDTH: operand B; captured on an accepted start.
- `c_in`, in, 1: carry-in; captured on an accepted start.
- `busy`, out, 1: high while bits are being processed.
- `done`, out, 1: one-cycle pulse when `s`/`c_out` update.
- `s`, out, WIDTH: registered sum; holds the last result until the next completion.
- `c_out`, out, 1: registered carry-out of the MSB; holds with `s`.

## Operation
- FSM states are IDLE, BUSY and DONE.
- IDLE: `start`=1 moves to BUSY and loads the shift registers from `a`/`b`, the carry FF from `c_in`, and the bit counter to 0. `start`=0 stays in IDLE.
- BUSY: the `fulladder` inputs are `a_sh[0]`, `b_sh[0]` and the carry FF. Each edge:
  - `a_sh` and `b_sh` shift right.
  - the sum bit shifts into `acc[WIDTH-1]` while `acc` shifts right.
  - the carry FF takes the full adder's `c_out`.
  - the counter increments.
- BUSY exit: on the edge where counter = WIDTH-1, go to DONE. On that same edge `s` <= final `acc` including the current sum bit, and `c_out` <= the full adder's carry.
- DONE: lasts one cycle. `start`=1 moves straight to BUSY and loads as in IDLE; otherwise go to IDLE.
- `start` in BUSY is ignored: operands are not recaptured and there is no queueing.
- Arithmetic: {`c_out`,`s`} = `a` + `b` + `c_in`, exact, modulo 2^(WIDTH+1).
- Counter width is $clog2(WIDTH).
- `a`, `b` and `c_in` are don't-care except on an accepted start edge.
- Reset, async and valid in any state including mid-BUSY:
  - state IDLE; `busy`=0, `done`=0, `s`=0, `c_out`=0.
  - shift registers, `acc`, carry FF and counter cleared.
  - any in-flight addition is discarded with no done.

## Timing
- `busy` = (state==BUSY). `done` = (state==DONE). Both decode a registered state.
- Accepted start at edge E0: `busy` high from E0 to E_WIDTH. `s`/`c_out` valid and `done` high from E_WIDTH to E_(WIDTH+1).
- Latency is WIDTH cycles from the start edge to the result.
- Throughput with start held or re-pulsed in DONE: one result per WIDTH+1 cycles.
- `s`/`c_out` change only on the DONE-entry edge or on reset; they are stable during BUSY.
- Release of `rst_n` is assumed synchronised externally. The first accepted start is the first edge after deassertion with `start`=1.

## Structure
- `serial_adder_pkg`: state enum (IDLE, BUSY, DONE) and the `WIDTH` legal-range constants.
- Sub-module: one instance of the existing `fulladder` (ports `a`, `b`, `c_in`, `s`, `c_out`). It is the only combinational arithmetic in the block.
- Registers: FSM state, `a_sh`, `b_sh`, `acc`, carry FF, counter, `s`, `c_out`.

## Test plan
All scenarios use WIDTH=8.
- `a`=0x00, `b`=0x00, `c_in`=0, start -> `busy` for 8 cycles, `done` 1 cycle, `s`=0x00, `c_out`=0.
- `a`=0xFF, `b`=0x01, `c_in`=0 -> `s`=0x00, `c_out`=1. Then `a`=0xA5, `b`=0x5A, `c_in`=1 -> `s`=0x00, `c_out`=1.
- `a`=0x3C, `b`=0x42, `c_in`=0 -> `s`=0x7E, `c_out`=0. A start pulse with `a`=0xFF, `b`=0xFF in the 3rd BUSY cycle is ignored, and the result is still 0x7E.
- `rst_n` low in the 4th BUSY cycle -> outputs immediately 0, state IDLE, no `done`. A following start with 0x10+0x20 yields 0x30.
- `start` held high: back-to-back `done` every 9 cycles, with results matching each operand pair presented on its accepting edge.
- All 2^17 combinations of `a`, `b`, `c_in` (or 10k random) checked against the reference model {`c_out`,`s`}=`a`+`b`+`c_in`. `s` must not change during BUSY.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package serial_adder_pkg;

    // Legal operand width range
    localparam int unsigned WIDTH_MIN     = 2;
    localparam int unsigned WIDTH_MAX     = 32;
    localparam int unsigned WIDTH_DEFAULT = 8;

    // Sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : serial_adder_pkg

// File: rtl/fulladder.sv
// Single-bit full adder cell.
// Latency: combinational, zero cycles.
// Backpressure: none; outputs follow inputs.
module fulladder (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic s,
    output logic c_out
);

    logic p;

    // Propagate term, sum, and carry.
    always_comb begin
        p     = a ^ b;
        s     = p ^ c_in;
        c_out = (a & b) | (c_in & p);
    end

endmodule : fulladder

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: sequences LSB-first bit pairs through one fulladder cell.
// Latency: WIDTH cycles from the accepted start edge to s/c_out/done.
// Backpressure: start is ignored while busy; no queueing. Accepted in IDLE or DONE.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             c_out
);

    // Reject out-of-range widths at elaboration time.
    if (WIDTH < int'(WIDTH_MIN) || WIDTH > int'(WIDTH_MAX)) begin : g_bad_width
        $error("serial_adder: WIDTH out of legal range");
    end

    localparam int              CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t             state;
    state_t             state_nxt;
    logic               load;
    logic               last_bit;

    logic [WIDTH-1:0]   a_sh;
    logic [WIDTH-1:0]   b_sh;
    logic [WIDTH-1:0]   acc;
    logic [WIDTH-1:0]   acc_nxt;
    logic               carry;
    logic [CNT_W-1:0]   cnt;

    logic               fa_s;
    logic               fa_c;

    // The only arithmetic in the block: one bit pair plus the held carry.
    fulladder u_fa (
        .a     (a_sh[0]),
        .b     (b_sh[0]),
        .c_in  (carry),
        .s     (fa_s),
        .c_out (fa_c)
    );

    // Accumulator shifts right; the fresh sum bit enters at the MSB so that
    // after WIDTH shifts the first (LSB) sum bit lands in position 0.
    always_comb begin
        acc_nxt = {fa_s, (WIDTH-1)'(acc >> 1)};
    end

    // Status decodes straight from the registered state.
    always_comb begin
        busy     = (state == BUSY);
        done     = (state == DONE);
        last_bit = (state == BUSY) && (cnt == CNT_LAST);
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and operand-load decode; DONE can restart directly.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = BUSY;
                    load      = 1'b1;
                end
            end
            BUSY: begin
                if (last_bit) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    state_nxt = BUSY;
                    load      = 1'b1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Operand shifters, carry FF, accumulator and bit counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh  <= '0;
            b_sh  <= '0;
            acc   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
        end else if (load) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= c_in;
            cnt   <= '0;
        end else if (state == BUSY) begin
            a_sh  <= a_sh >> 1;
            b_sh  <= b_sh >> 1;
            acc   <= acc_nxt;
            carry <= fa_c;
            cnt   <= cnt + CNT_W'(1);
        end
    end

    // Result registers update only on the DONE-entry edge, so they stay
    // stable for the whole BUSY window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s     <= '0;
            c_out <= 1'b0;
        end else if (last_bit) begin
            s     <= acc_nxt;
            c_out <= fa_c;
        end
    end

endmodule : serial_adder

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8) with a plain-arithmetic reference.
// Latency: n/a.
// Backpressure: n/a.
module tb_serial_adder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c_in;
    logic         busy;
    logic         done;
    logic [W-1:0] s;
    logic         c_out;

    int n_vec  = 0;
    int n_miss = 0;

    // Reference-visible result: what s/c_out must hold outside DONE entry.
    logic [W-1:0] ref_s;
    logic         ref_c;

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .c_in  (c_in),
        .busy  (busy),
        .done  (done),
        .s     (s),
        .c_out (c_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [W:0] model_sum(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input logic ci);
        return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
    endfunction

    task automatic scramble();
        a    = W'($urandom);
        b    = W'($urandom);
        c_in = 1'($urandom);
    endtask

    // One addition from idle: checks busy/done timing, result hold during
    // busy, and the final sum. inj>0 pulses start with FF+FF in that busy cycle.
    task automatic run_add(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci,
                           input int inj);
        logic [W:0] exp;
        exp = model_sum(x, y, ci);
        @(negedge clk);
        a = x; b = y; c_in = ci; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        scramble();
        chk("busy_e0", 32'(busy), 32'd1);
        for (int i = 1; i <= W; i++) begin
            @(negedge clk);
            if (i == inj) begin
                start = 1'b1; a = 8'hFF; b = 8'hFF; c_in = 1'b1;
            end else begin
                start = 1'b0;
                scramble();
            end
            @(posedge clk); #1;
            if (i < W) begin
                chk("busy_mid", 32'(busy), 32'd1);
                chk("done_mid", 32'(done), 32'd0);
                chk("s_hold", 32'(s), 32'(ref_s));
                chk("c_hold", 32'(c_out), 32'(ref_c));
            end else begin
                chk("busy_end", 32'(busy), 32'd0);
                chk("done_end", 32'(done), 32'd1);
                chk("sum", 32'(s), 32'(exp[W-1:0]));
                chk("carry", 32'(c_out), 32'(exp[W]));
                ref_s = exp[W-1:0];
                ref_c = exp[W];
            end
        end
        @(negedge clk);
        start = 1'b0;
        @(posedge clk); #1;
        chk("done_drop", 32'(done), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        logic [W:0] q_exp[$];
        logic [W:0] e;

        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; c_in = 1'b0;
        ref_s = '0; ref_c = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_s", 32'(s), 32'd0);
        chk("rst_c", 32'(c_out), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed corners.
        run_add(8'h00, 8'h00, 1'b0, 0);
        run_add(8'hFF, 8'h01, 1'b0, 0);
        run_add(8'hA5, 8'h5A, 1'b1, 0);
        run_add(8'h3C, 8'h42, 1'b0, 3);
        run_add(8'hFF, 8'hFF, 1'b1, 0);
        run_add(8'h80, 8'h80, 1'b0, 0);
        run_add(8'h7F, 8'h00, 1'b1, 0);

        // Reset during the 4th busy cycle discards the addition.
        @(negedge clk);
        a = 8'h3C; b = 8'h42; c_in = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_s", 32'(s), 32'd0);
        chk("arst_c", 32'(c_out), 32'd0);
        ref_s = '0; ref_c = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            chk("arst_nodone", 32'(done), 32'd0);
            chk("arst_idle", 32'(busy), 32'd0);
        end
        run_add(8'h10, 8'h20, 1'b0, 0);

        // start held high: accepts on edges 0, 9, 18, ...; done on edges 8, 17, ...
        for (int k = 0; k < 45; k++) begin
            @(negedge clk);
            start = 1'b1;
            scramble();
            if (k % 9 == 0) q_exp.push_back(model_sum(a, b, c_in));
            @(posedge clk); #1;
            if (k % 9 == 8) begin
                chk("bb_done", 32'(done), 32'd1);
                if (q_exp.size() > 0) begin
                    e = q_exp.pop_front();
                    chk("bb_sum", 32'({c_out, s}), 32'(e));
                end else begin
                    chk("bb_queue", 32'd0, 32'd1);
                end
            end else begin
                chk("bb_nodone", 32'(done), 32'd0);
                chk("bb_busy", 32'(busy), 32'd1);
            end
        end
        @(negedge clk);
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("bb_idle", 32'(busy), 32'd0);
        e = {c_out, s};
        ref_s = e[W-1:0];
        ref_c = e[W];

        // Random operands against the arithmetic reference.
        for (int n = 0; n < 1500; n++) begin
            run_add(W'($urandom), W'($urandom), 1'($urandom), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule : tb_serial_adder
